// File: rtl/control_multi_fsm.sv
// control_multi_fsm: multicycle RV32I(M) control unit, Moore FSM fetch/decode/execute/mem/writeback.
// Latency: 3-5 cycles per instruction, plus MULDIV_CYCLES in EXEC_MD and any memory stall cycles.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until iMemReady. Optional MUL/DIV: define MULDIV_EN.
module control_multi_fsm #(
  parameter int ALUCTRL_W     = 5,
  parameter int MULDIV_CYCLES = 34,  // >= 1
  parameter int CNT_W         = 6    // 2**CNT_W must exceed MULDIV_CYCLES
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [31:0]          iInstr,
  input  logic                 iMemReady,
  output logic                 oIRWrite,
  output logic                 oPCWrite,
  output logic                 oPCWriteCond,
  output logic                 oIorD,
  output logic                 oMemRead,
  output logic                 oMemWrite,
  output logic                 oRegWrite,
  output logic [1:0]           oOrigAULA,
  output logic [1:0]           oOrigBULA,
  output logic [1:0]           oMem2Reg,
  output logic [1:0]           oOrigPC,
  output logic [ALUCTRL_W-1:0] oALUControl,
  output logic                 oIllegal,
  output logic [3:0]           oState
);

  // ALU operation codes; the M ops occupy OPMUL+funct3 (MUL..REMU = 11..18)
  localparam logic [ALUCTRL_W-1:0] OPAND  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] OPOR   = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] OPXOR  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] OPADD  = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] OPSUB  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] OPSLT  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] OPSLTU = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] OPSLL  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] OPSRL  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] OPSRA  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] OPLUI  = ALUCTRL_W'(10);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WB = 4'd6, S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8, S_JAL = 4'd9, S_JALR = 4'd10, S_LUI = 4'd11,
    S_AUIPC = 4'd12, S_ALU_WB = 4'd13, S_EXEC_MD = 4'd14, S_ILLEGAL = 4'd15
  } state_t;

  state_t state;
  state_t dec_next;
  logic [ALUCTRL_W-1:0] int_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];

  // register indices belong to the datapath, not to sequencing
  logic unused_instr;
  assign unused_instr = ^{iInstr[24:15], iInstr[11:7]};

`ifdef MULDIV_EN
  localparam logic [ALUCTRL_W-1:0] OPMUL = ALUCTRL_W'(11);
  logic [CNT_W-1:0]     md_cnt;
  logic [ALUCTRL_W-1:0] md_op;
  assign md_op = OPMUL + ALUCTRL_W'(funct3);

  // reload in every DECODE so the count is fresh on entry to EXEC_MD, then count down to 0
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)
      md_cnt <= '0;
    else if (state == S_DECODE)
      md_cnt <= CNT_W'(MULDIV_CYCLES - 1);
    else if (state == S_EXEC_MD && md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end
`else
  localparam int unused_md_cfg = MULDIV_CYCLES + CNT_W;
`endif

  // instruction classification in DECODE; anything not explicitly legal goes to ILLEGAL
  always_comb begin
    dec_next = S_ILLEGAL;
    case (opcode)
      OPC_LOAD:   if (funct3 != 3'b011 && funct3[2:1] != 2'b11) dec_next = S_ADDR;
      OPC_STORE:  if (!funct3[2] && funct3 != 3'b011) dec_next = S_ADDR;
      OPC_OPIMM: begin
        if (funct3 == 3'b001)
          dec_next = (funct7 == F7_BASE) ? S_EXEC_I : S_ILLEGAL;
        else if (funct3 == 3'b101)
          dec_next = (funct7 == F7_BASE || funct7 == F7_ALT) ? S_EXEC_I : S_ILLEGAL;
        else
          dec_next = S_EXEC_I;
      end
      OPC_RTYPE: begin
        if (funct7 == F7_BASE)
          dec_next = S_EXEC_R;
        else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
          dec_next = S_EXEC_R;
`ifdef MULDIV_EN
        else if (funct7 == F7_MD)
          dec_next = S_EXEC_MD;
`endif
        else
          dec_next = S_ILLEGAL;
      end
      OPC_BRANCH: if (funct3[2:1] != 2'b01) dec_next = S_BRANCH;
      OPC_JAL:    dec_next = S_JAL;
      OPC_JALR:   if (funct3 == 3'b000) dec_next = S_JALR;
      OPC_LUI:    dec_next = S_LUI;
      OPC_AUIPC:  dec_next = S_AUIPC;
      default:    dec_next = S_ILLEGAL;
    endcase
  end

  // integer ALU op; funct7[5] selects SUB only for register ops, SRA for both
  always_comb begin
    int_op = OPADD;
    case (funct3)
      3'b000:  int_op = (opcode == OPC_RTYPE && funct7[5]) ? OPSUB : OPADD;
      3'b001:  int_op = OPSLL;
      3'b010:  int_op = OPSLT;
      3'b011:  int_op = OPSLTU;
      3'b100:  int_op = OPXOR;
      3'b101:  int_op = funct7[5] ? OPSRA : OPSRL;
      3'b110:  int_op = OPOR;
      default: int_op = OPAND;
    endcase
  end

  // state sequencing; memory states stall on iMemReady
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (iMemReady) state <= S_DECODE;
        S_DECODE: state <= dec_next;
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state <= S_ALU_WB;
        S_ADDR:   state <= (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (iMemReady) state <= S_MEM_WB;
        S_MEM_WR: if (iMemReady) state <= S_FETCH;
`ifdef MULDIV_EN
        S_EXEC_MD: if (md_cnt == '0) state <= S_ALU_WB;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode, forced to 0 while reset is asserted. The IR/PC load in FETCH is
  // qualified by iMemReady so a stalled fetch never captures stale memory data.
  always_comb begin
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oRegWrite    = 1'b0;
    oOrigAULA    = 2'b00;
    oOrigBULA    = 2'b00;
    oMem2Reg     = 2'b00;
    oOrigPC      = 2'b00;
    oALUControl  = '0;
    oIllegal     = 1'b0;
    oState       = 4'd0;
    if (iRST) begin
      oState = state;
      case (state)
        S_FETCH: begin
          oMemRead = 1'b1; oOrigBULA = 2'b01; oALUControl = OPADD;
          oIRWrite = iMemReady; oPCWrite = iMemReady;
        end
        S_DECODE:  begin oOrigAULA = 2'b10; oOrigBULA = 2'b10; oALUControl = OPADD; end
        S_EXEC_R:  begin oOrigAULA = 2'b01; oOrigBULA = 2'b00; oALUControl = int_op; end
        S_EXEC_I:  begin oOrigAULA = 2'b01; oOrigBULA = 2'b10; oALUControl = int_op; end
        S_ALU_WB:  begin oRegWrite = 1'b1; oMem2Reg = 2'b00; end
        S_LUI:     begin oOrigBULA = 2'b10; oALUControl = OPLUI; end
        S_AUIPC:   begin oOrigAULA = 2'b10; oOrigBULA = 2'b10; oALUControl = OPADD; end
        S_ADDR:    begin oOrigAULA = 2'b01; oOrigBULA = 2'b10; oALUControl = OPADD; end
        S_MEM_RD:  begin oIorD = 1'b1; oMemRead = 1'b1; end
        S_MEM_WB:  begin oRegWrite = 1'b1; oMem2Reg = 2'b10; end
        S_MEM_WR:  begin oIorD = 1'b1; oMemWrite = 1'b1; end
        S_BRANCH: begin
          oOrigAULA = 2'b01; oOrigBULA = 2'b00; oALUControl = OPSUB;
          oPCWriteCond = 1'b1; oOrigPC = 2'b01;
        end
        S_JAL: begin
          oPCWrite = 1'b1; oOrigPC = 2'b01; oRegWrite = 1'b1; oMem2Reg = 2'b01;
        end
        S_JALR: begin
          oOrigAULA = 2'b01; oOrigBULA = 2'b10; oALUControl = OPADD;
          oPCWrite = 1'b1; oOrigPC = 2'b10; oRegWrite = 1'b1; oMem2Reg = 2'b01;
        end
        S_EXEC_MD: begin
`ifdef MULDIV_EN
          oOrigAULA = 2'b01; oOrigBULA = 2'b00; oALUControl = md_op;
`endif
        end
        S_ILLEGAL: oIllegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multi_fsm.sv
// tb_control_multi_fsm: scoreboarded cycle-by-cycle check of control_multi_fsm outputs.
// Each step pushes stimulus plus expected outputs/care mask; the step is popped and compared at negedge+1.
// Covers reset, R/I/U/J/branch/load/store flows, memory stalls, MUL/DIV timing, illegal and async reset.
module tb_control_multi_fsm;

  localparam logic [4:0] OPADD = 5'd3, OPSUB = 5'd4, OPSRA = 5'd9, OPLUI = 5'd10;
  localparam logic [4:0] OPMUL = 5'd11, OPMULHU = 5'd14, OPREMU = 5'd18;
  localparam int MD = 34;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2, ST_EXEC_I = 4'd3;
  localparam logic [3:0] ST_ADDR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WB = 4'd6, ST_MEM_WR = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8, ST_JAL = 4'd9, ST_JALR = 4'd10, ST_LUI = 4'd11;
  localparam logic [3:0] ST_AUIPC = 4'd12, ST_ALU_WB = 4'd13, ST_EXEC_MD = 4'd14, ST_ILLEGAL = 4'd15;

  typedef struct packed {
    logic       irw, pcw, pcwc, iord, mrd, mwr, rw;
    logic [1:0] a, b, m2r, opc;
    logic [4:0] alu;
    logic       ill;
    logic [3:0] st;
  } ctl_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        mr;
  } stim_t;

  logic        iCLK, iRST, iMemReady;
  logic [31:0] iInstr;
  logic        oIRWrite, oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oRegWrite, oIllegal;
  logic [1:0]  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC;
  logic [4:0]  oALUControl;
  logic [3:0]  oState;

  ctl_t  act;
  stim_t stim_q[$];
  ctl_t  exp_q[$];
  ctl_t  care_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  control_multi_fsm dut (
    .iCLK(iCLK), .iRST(iRST), .iInstr(iInstr), .iMemReady(iMemReady),
    .oIRWrite(oIRWrite), .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond), .oIorD(oIorD),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oRegWrite(oRegWrite),
    .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA), .oMem2Reg(oMem2Reg), .oOrigPC(oOrigPC),
    .oALUControl(oALUControl), .oIllegal(oIllegal), .oState(oState)
  );

  assign act = {oIRWrite, oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oRegWrite,
                oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oALUControl, oIllegal, oState};

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Expected outputs per state, straight from the control table; fields the table leaves open are masked out.
  function automatic void add(input logic [31:0] ins, input logic mr, input logic [3:0] st,
                              input logic [4:0] alu);
    ctl_t e, c;
    stim_t s;
    e = '0; c = '0;
    c.irw = 1'b1; c.pcw = 1'b1; c.pcwc = 1'b1; c.mrd = 1'b1; c.mwr = 1'b1; c.rw = 1'b1;
    c.ill = 1'b1; c.st = 4'hF; e.st = st;
    case (st)
      ST_FETCH: begin
        e.mrd = 1'b1; c.iord = 1'b1; e.a = 2'b00; e.b = 2'b01; c.a = 2'b11; c.b = 2'b11;
        e.alu = OPADD; c.alu = 5'h1F; c.opc = 2'b11; e.irw = mr; e.pcw = mr;
      end
      ST_DECODE: begin e.a = 2'b10; e.b = 2'b10; c.a = 2'b11; c.b = 2'b11; e.alu = OPADD; c.alu = 5'h1F; end
      ST_EXEC_R, ST_EXEC_MD: begin e.a = 2'b01; e.b = 2'b00; c.a = 2'b11; c.b = 2'b11; e.alu = alu; c.alu = 5'h1F; end
      ST_EXEC_I: begin e.a = 2'b01; e.b = 2'b10; c.a = 2'b11; c.b = 2'b11; e.alu = alu; c.alu = 5'h1F; end
      ST_ALU_WB: begin e.rw = 1'b1; e.m2r = 2'b00; c.m2r = 2'b11; end
      ST_LUI:    begin e.b = 2'b10; c.b = 2'b11; e.alu = OPLUI; c.alu = 5'h1F; end
      ST_AUIPC, ST_ADDR: begin
        e.a = (st == ST_AUIPC) ? 2'b10 : 2'b01; e.b = 2'b10; c.a = 2'b11; c.b = 2'b11;
        e.alu = OPADD; c.alu = 5'h1F;
      end
      ST_MEM_RD: begin e.iord = 1'b1; c.iord = 1'b1; e.mrd = 1'b1; end
      ST_MEM_WB: begin e.rw = 1'b1; e.m2r = 2'b10; c.m2r = 2'b11; end
      ST_MEM_WR: begin e.iord = 1'b1; c.iord = 1'b1; e.mwr = 1'b1; end
      ST_BRANCH: begin
        e.a = 2'b01; e.b = 2'b00; c.a = 2'b11; c.b = 2'b11; e.alu = OPSUB; c.alu = 5'h1F;
        e.pcwc = 1'b1; e.opc = 2'b01; c.opc = 2'b11;
      end
      ST_JAL: begin e.pcw = 1'b1; e.opc = 2'b01; c.opc = 2'b11; e.rw = 1'b1; e.m2r = 2'b01; c.m2r = 2'b11; end
      ST_JALR: begin
        e.a = 2'b01; e.b = 2'b10; c.a = 2'b11; c.b = 2'b11; e.alu = OPADD; c.alu = 5'h1F;
        e.pcw = 1'b1; e.opc = 2'b10; c.opc = 2'b11; e.rw = 1'b1; e.m2r = 2'b01; c.m2r = 2'b11;
      end
      ST_ILLEGAL: e.ill = 1'b1;
      default: ;
    endcase
    s.ins = ins; s.mr = mr;
    stim_q.push_back(s); exp_q.push_back(e); care_q.push_back(c);
  endfunction

  function automatic void add_fd(input logic [31:0] ins);
    add(ins, 1'b1, ST_FETCH, 5'd0);
    add(ins, 1'b1, ST_DECODE, 5'd0);
  endfunction

  task automatic test_reset;
    iRST = 1'b0; iMemReady = 1'b1; iInstr = 32'h002081B3;
    repeat (2) @(negedge iCLK);
    #1;
    n_cmp++;
    if (act !== '0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", act); end
    iMemReady = 1'b0; iInstr = 32'h0000007F; #1;
    n_cmp++;
    if (act !== '0) begin n_err++; $display("FAIL reset_inputs_ignored: got %h expected 0", act); end
    @(negedge iCLK); iRST = 1'b1; #1;
    n_cmp++;
    if (oState !== ST_FETCH || oMemRead !== 1'b1 || oIRWrite !== 1'b0) begin
      n_err++; $display("FAIL reset_release: state %0d mrd %b irw %b expected 0/1/0", oState, oMemRead, oIRWrite);
    end
  endtask

  task automatic test_add;
    stim_t s; ctl_t e, c; int k = 0;
    add_fd(32'h002081B3);
    add(32'h002081B3, 1'b1, ST_EXEC_R, OPADD);
    add(32'h002081B3, 1'b1, ST_ALU_WB, 5'd0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = care_q.pop_front();
      @(negedge iCLK); iInstr = s.ins; iMemReady = s.mr; #1;
      n_cmp++;
      if ((act & c) !== (e & c)) begin
        n_err++; $display("FAIL add step %0d: got %h expected %h mask %h", k, act, e, c);
      end
      k++;
    end
  endtask

  task automatic test_load_stall;
    stim_t s; ctl_t e, c; int k = 0;
    add_fd(32'h0080A283);
    add(32'h0080A283, 1'b1, ST_ADDR, 5'd0);
    for (int i = 0; i < 3; i++) add(32'h0080A283, 1'b0, ST_MEM_RD, 5'd0);
    add(32'h0080A283, 1'b1, ST_MEM_RD, 5'd0);
    add(32'h0080A283, 1'b0, ST_MEM_WB, 5'd0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = care_q.pop_front();
      @(negedge iCLK); iInstr = s.ins; iMemReady = s.mr; #1;
      n_cmp++;
      if ((act & c) !== (e & c)) begin
        n_err++; $display("FAIL load_stall step %0d: got %h expected %h mask %h", k, act, e, c);
      end
      k++;
    end
  endtask

  task automatic test_branch_jal;
    stim_t s; ctl_t e, c; int k = 0;
    add_fd(32'h00208463);
    add(32'h00208463, 1'b1, ST_BRANCH, 5'd0);
    add_fd(32'h010000EF);
    add(32'h010000EF, 1'b1, ST_JAL, 5'd0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = care_q.pop_front();
      @(negedge iCLK); iInstr = s.ins; iMemReady = s.mr; #1;
      n_cmp++;
      if ((act & c) !== (e & c)) begin
        n_err++; $display("FAIL branch_jal step %0d: got %h expected %h mask %h", k, act, e, c);
      end
      k++;
    end
  endtask

  task automatic test_muldiv;
    stim_t s; ctl_t e, c; int k = 0;
    logic [31:0] ins [3];
    logic [4:0]  op  [3];
    ins[0] = 32'h022081B3; op[0] = OPMUL;    // mul
    ins[1] = 32'h0220B1B3; op[1] = OPMULHU;  // mulhu
    ins[2] = 32'h0220F1B3; op[2] = OPREMU;   // remu
    for (int j = 0; j < 3; j++) begin
      add_fd(ins[j]);
`ifdef MULDIV_EN
      for (int i = 0; i < MD; i++) add(ins[j], 1'b1, ST_EXEC_MD, op[j]);
      add(ins[j], 1'b1, ST_ALU_WB, 5'd0);
`else
      add(ins[j], 1'b1, ST_ILLEGAL, op[j]);
`endif
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = care_q.pop_front();
      @(negedge iCLK); iInstr = s.ins; iMemReady = s.mr; #1;
      n_cmp++;
      if ((act & c) !== (e & c)) begin
        n_err++; $display("FAIL muldiv step %0d: got %h expected %h mask %h", k, act, e, c);
      end
      k++;
    end
  endtask

  task automatic test_illegal;
    stim_t s; ctl_t e, c; int k = 0;
    add_fd(32'h0000007F);
    add(32'h0000007F, 1'b1, ST_ILLEGAL, 5'd0);
    add(32'h0000007F, 1'b0, ST_FETCH, 5'd0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = care_q.pop_front();
      @(negedge iCLK); iInstr = s.ins; iMemReady = s.mr; #1;
      n_cmp++;
      if ((act & c) !== (e & c)) begin
        n_err++; $display("FAIL illegal step %0d: got %h expected %h mask %h", k, act, e, c);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back;
    stim_t s; ctl_t e, c; int k = 0;
    add_fd(32'h00500093); add(32'h00500093, 1'b1, ST_EXEC_I, OPADD); add(32'h00500093, 1'b1, ST_ALU_WB, 5'd0);
    add_fd(32'h123452B7); add(32'h123452B7, 1'b1, ST_LUI, OPLUI);    add(32'h123452B7, 1'b1, ST_ALU_WB, 5'd0);
    add_fd(32'h00001317); add(32'h00001317, 1'b1, ST_AUIPC, OPADD);  add(32'h00001317, 1'b1, ST_ALU_WB, 5'd0);
    add_fd(32'h00008067); add(32'h00008067, 1'b1, ST_JALR, OPADD);
    add_fd(32'h402081B3); add(32'h402081B3, 1'b1, ST_EXEC_R, OPSUB); add(32'h402081B3, 1'b1, ST_ALU_WB, 5'd0);
    add_fd(32'h4030D093); add(32'h4030D093, 1'b1, ST_EXEC_I, OPSRA); add(32'h4030D093, 1'b1, ST_ALU_WB, 5'd0);
    add_fd(32'h40309093); add(32'h40309093, 1'b1, ST_ILLEGAL, 5'd0);
    add(32'h0020A223, 1'b0, ST_FETCH, 5'd0);
    add_fd(32'h0020A223); add(32'h0020A223, 1'b1, ST_ADDR, OPADD);
    add(32'h0020A223, 1'b0, ST_MEM_WR, 5'd0); add(32'h0020A223, 1'b1, ST_MEM_WR, 5'd0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = care_q.pop_front();
      @(negedge iCLK); iInstr = s.ins; iMemReady = s.mr; #1;
      n_cmp++;
      if ((act & c) !== (e & c)) begin
        n_err++; $display("FAIL back_to_back step %0d: got %h expected %h mask %h", k, act, e, c);
      end
      k++;
    end
  endtask

  task automatic test_store_reset;
    stim_t s; ctl_t e, c; int k = 0;
    add_fd(32'h0020A223);
    add(32'h0020A223, 1'b1, ST_ADDR, OPADD);
    add(32'h0020A223, 1'b0, ST_MEM_WR, 5'd0);
    add(32'h0020A223, 1'b0, ST_MEM_WR, 5'd0);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); c = care_q.pop_front();
      @(negedge iCLK); iInstr = s.ins; iMemReady = s.mr; #1;
      n_cmp++;
      if ((act & c) !== (e & c)) begin
        n_err++; $display("FAIL store_reset step %0d: got %h expected %h mask %h", k, act, e, c);
      end
      k++;
    end
    #2 iRST = 1'b0; #1;
    n_cmp++;
    if (act !== '0) begin n_err++; $display("FAIL store_reset_drop: got %h expected 0", act); end
    @(negedge iCLK); #1;
    n_cmp++;
    if (act !== '0) begin n_err++; $display("FAIL store_reset_hold: got %h expected 0", act); end
    iRST = 1'b1; #1;
    n_cmp++;
    if (oState !== ST_FETCH || oMemRead !== 1'b1 || oMemWrite !== 1'b0 || oIorD !== 1'b0) begin
      n_err++;
      $display("FAIL store_reset_restart: state %0d mrd %b mwr %b iord %b expected 0/1/0/0",
               oState, oMemRead, oMemWrite, oIorD);
    end
  endtask

  initial begin
    iRST = 1'b0; iMemReady = 1'b0; iInstr = '0;
    test_reset();
    test_add();
    test_load_stall();
    test_branch_jal();
    test_muldiv();
    test_illegal();
    test_back_to_back();
    test_store_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
